// File: rtl/id_stage_hz.sv
// id_stage_hz: decode, register file, hazard stall, flush and ID/EX register.
// Optional macro ID_WB_BYPASS_EN forwards same-cycle write-back on reads.
module id_stage_hz #(
  parameter int DATA_W   = 32,
  parameter int PC_W     = 11,
  parameter int NUM_REGS = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [31:0]       instruction,
  input  logic [PC_W-1:0]   current_pc,
  input  logic              if_valid,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [4:0]        wb_addr,
  input  logic              wb_reg_write,
  input  logic              ex_mem_read,
  input  logic [4:0]        ex_rt,
  input  logic              flush,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  output logic [DATA_W-1:0] sign_extended,
  output logic [PC_W-1:0]   branch_target,
  output logic [4:0]        rs_out,
  output logic [4:0]        reg_dest_r_type,
  output logic [4:0]        reg_dest_l_type,
  output logic              RegDst_out,
  output logic              ALUSrc_out,
  output logic              MemToReg_out,
  output logic              RegWrite_out,
  output logic              MemRead_out,
  output logic              MemWrite_out,
  output logic              Branch_out,
  output logic [1:0]        ALUOp_out,
  output logic              illegal_out
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [5:0] NR = 6'(NUM_REGS);

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;

  assign op  = instruction[31:26];
  assign rs  = instruction[25:21];
  assign rt  = instruction[20:16];
  assign rd  = instruction[15:11];
  assign imm = instruction[15:0];

  logic [DATA_W-1:0] regs [NUM_REGS];

  function automatic logic [DATA_W-1:0] rd_reg(
    input logic [4:0] a
  );
    logic [DATA_W-1:0] v;
    v = '0;
    if (a != 5'd0 && {1'b0, a} < NR)
      v = regs[a[AW-1:0]];
`ifdef ID_WB_BYPASS_EN
    if (wb_reg_write && a != 5'd0 && a == wb_addr)
      v = wb_data;
`endif
    return v;
  endfunction

  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;

  assign rd_a     = rd_reg(rs);
  assign rd_b     = rd_reg(rt);
  assign dbg_data = rd_reg(dbg_addr);

  logic is_r;
  logic is_lw;
  logic is_sw;
  logic is_beq;
  logic is_addi;

  assign is_r    = (op == 6'h00);
  assign is_lw   = (op == 6'h23);
  assign is_sw   = (op == 6'h2B);
  assign is_beq  = (op == 6'h04);
  assign is_addi = (op == 6'h08);

  // {dst, src, m2r, rw, mr, mw, br, aluop[1:0], illegal}
  logic [9:0] ctl;

  // Opcode to control-bundle decode
  always_comb begin
    ctl = 10'b0;
    unique case (1'b1)
      is_r:    ctl = 10'b1001000100;
      is_lw:   ctl = 10'b0111100000;
      is_sw:   ctl = 10'b0100010000;
      is_beq:  ctl = 10'b0000001010;
      is_addi: ctl = 10'b0101000000;
      default: ctl = 10'b0000000001;
    endcase
  end

  logic uses_rt;
  logic load;

  assign uses_rt = is_r | is_sw | is_beq;

  assign stall = if_valid & ex_valid & ex_mem_read
               & (ex_rt != 5'd0)
               & ((ex_rt == rs) | (uses_rt & (ex_rt == rt)))
               & ~flush;

  assign load = if_valid & ~flush & ~stall;

  logic [DATA_W-1:0] sext;
  logic [PC_W-1:0]   target;

  assign sext   = DATA_W'($signed(imm));
  assign target = current_pc + PC_W'($signed({imm, 2'b00}));

  // Register file write port; r0 is never stored
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (wb_reg_write && wb_addr[AW-1:0] != '0) begin
      regs[wb_addr[AW-1:0]] <= wb_data;
    end
  end

  // ID/EX register: load decoded instruction or insert a bubble
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n || !load) begin
      ex_valid        <= 1'b0;
      data_a          <= '0;
      data_b          <= '0;
      sign_extended   <= '0;
      branch_target   <= '0;
      rs_out          <= '0;
      reg_dest_r_type <= '0;
      reg_dest_l_type <= '0;
      RegDst_out      <= 1'b0;
      ALUSrc_out      <= 1'b0;
      MemToReg_out    <= 1'b0;
      RegWrite_out    <= 1'b0;
      MemRead_out     <= 1'b0;
      MemWrite_out    <= 1'b0;
      Branch_out      <= 1'b0;
      ALUOp_out       <= 2'b0;
      illegal_out     <= 1'b0;
    end else begin
      ex_valid        <= 1'b1;
      data_a          <= rd_a;
      data_b          <= rd_b;
      sign_extended   <= sext;
      branch_target   <= target;
      rs_out          <= rs;
      reg_dest_r_type <= rd;
      reg_dest_l_type <= rt;
      RegDst_out      <= ctl[9];
      ALUSrc_out      <= ctl[8];
      MemToReg_out    <= ctl[7];
      RegWrite_out    <= ctl[6];
      MemRead_out     <= ctl[5];
      MemWrite_out    <= ctl[4];
      Branch_out      <= ctl[3];
      ALUOp_out       <= ctl[2:1];
      illegal_out     <= ctl[0];
    end
  end

endmodule

// File: tb/tb_id_stage_hz.sv
// tb_id_stage_hz: directed and random checks of id_stage_hz
// against a table-driven pipeline model.
module tb_id_stage_hz;

  localparam int DW = 32;
  localparam int PW = 11;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [31:0]   instruction = '0;
  logic [PW-1:0] current_pc = '0;
  logic          if_valid = 1'b0;
  logic [DW-1:0] wb_data = '0;
  logic [4:0]    wb_addr = '0;
  logic          wb_reg_write = 1'b0;
  logic          ex_mem_read = 1'b0;
  logic [4:0]    ex_rt = '0;
  logic          flush = 1'b0;
  logic [4:0]    dbg_addr = '0;
  logic [DW-1:0] dbg_data;
  logic          stall;
  logic          ex_valid;
  logic [DW-1:0] data_a;
  logic [DW-1:0] data_b;
  logic [DW-1:0] sign_extended;
  logic [PW-1:0] branch_target;
  logic [4:0]    rs_out;
  logic [4:0]    reg_dest_r_type;
  logic [4:0]    reg_dest_l_type;
  logic          RegDst_out;
  logic          ALUSrc_out;
  logic          MemToReg_out;
  logic          RegWrite_out;
  logic          MemRead_out;
  logic          MemWrite_out;
  logic          Branch_out;
  logic [1:0]    ALUOp_out;
  logic          illegal_out;

  id_stage_hz #(.DATA_W(DW), .PC_W(PW), .NUM_REGS(32)) dut (
    .clock(clock), .reset_n(reset_n),
    .instruction(instruction), .current_pc(current_pc),
    .if_valid(if_valid), .wb_data(wb_data), .wb_addr(wb_addr),
    .wb_reg_write(wb_reg_write), .ex_mem_read(ex_mem_read),
    .ex_rt(ex_rt), .flush(flush), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data), .stall(stall), .ex_valid(ex_valid),
    .data_a(data_a), .data_b(data_b),
    .sign_extended(sign_extended), .branch_target(branch_target),
    .rs_out(rs_out), .reg_dest_r_type(reg_dest_r_type),
    .reg_dest_l_type(reg_dest_l_type),
    .RegDst_out(RegDst_out), .ALUSrc_out(ALUSrc_out),
    .MemToReg_out(MemToReg_out), .RegWrite_out(RegWrite_out),
    .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out),
    .Branch_out(Branch_out), .ALUOp_out(ALUOp_out),
    .illegal_out(illegal_out)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic          ev;
    logic [DW-1:0] da;
    logic [DW-1:0] db;
    logic [DW-1:0] se;
    logic [PW-1:0] bt;
    logic [4:0]    rs;
    logic [4:0]    rdr;
    logic [4:0]    rdl;
    logic [9:0]    ctl;
  } exp_t;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] mr [32];
  bit            m_exv = 1'b0;

  function automatic exp_t observe();
    return {ex_valid, data_a, data_b, sign_extended, branch_target,
            rs_out, reg_dest_r_type, reg_dest_l_type,
            RegDst_out, ALUSrc_out, MemToReg_out, RegWrite_out,
            MemRead_out, MemWrite_out, Branch_out, ALUOp_out,
            illegal_out};
  endfunction

  function automatic logic [DW-1:0] mread(input logic [4:0] a);
    if (a == 5'd0) return '0;
`ifdef ID_WB_BYPASS_EN
    if (wb_reg_write && wb_addr == a) return wb_data;
`endif
    return mr[a];
  endfunction

  // control table: RegDst ALUSrc MemToReg RegWrite MemRead MemWrite Branch ALUOp illegal
  function automatic logic [9:0] ctl_of(input logic [5:0] op);
    case (op)
      6'h00:   return {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0};
      6'h23:   return {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
      6'h2B:   return {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0};
      6'h04:   return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0};
      6'h08:   return {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
      default: return 10'b0000000001;
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mr[i] = '0;
    m_exv = 1'b0;
  endtask

  // predicts stall now and the ID/EX contents after the next edge
  task automatic model_step(output exp_t e, output bit st);
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] se;
    logic [31:0] t;
    bit          urt;
    op  = instruction[31:26];
    rs  = instruction[25:21];
    rt  = instruction[20:16];
    urt = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
    st  = if_valid && m_exv && ex_mem_read && ex_rt != 0
          && (ex_rt == rs || (urt && ex_rt == rt)) && !flush;
    e = '0;
    if (if_valid && !flush && !st) begin
      se = {{16{instruction[15]}}, instruction[15:0]};
      t  = 32'(current_pc) + (se << 2);
      e.ev  = 1'b1;
      e.da  = mread(rs);
      e.db  = mread(rt);
      e.se  = se;
      e.bt  = t[PW-1:0];
      e.rs  = rs;
      e.rdr = instruction[15:11];
      e.rdl = rt;
      e.ctl = ctl_of(op);
    end
    m_exv = e.ev;
    if (wb_reg_write && wb_addr != 0) mr[wb_addr] = wb_data;
  endtask

  task automatic drive(
    input logic [31:0]   ins,
    input logic [PW-1:0] pc,
    input logic          ifv,
    input logic          wbw,
    input logic [4:0]    wba,
    input logic [DW-1:0] wbd,
    input logic          exmr,
    input logic [4:0]    exrt,
    input logic          fl
  );
    instruction  = ins;
    current_pc   = pc;
    if_valid     = ifv;
    wb_reg_write = wbw;
    wb_addr      = wba;
    wb_data      = wbd;
    ex_mem_read  = exmr;
    ex_rt        = exrt;
    flush        = fl;
  endtask

  function automatic logic [31:0] rtype(
    input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd
  );
    return {6'h00, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] itype(
    input logic [5:0] op, input logic [4:0] rs,
    input logic [4:0] rt, input logic [15:0] imm
  );
    return {op, rs, rt, imm};
  endfunction

  task automatic test_reset();
    exp_t o;
    o = observe();
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL reset_regs: got %h want 0", o);
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall: got %b want 0", stall);
    end
    dbg_addr = 5'($urandom_range(1, 31));
    #1;
    checks++;
    if (dbg_data !== '0) begin
      errors++;
      $display("FAIL reset_dbg: got %h want 0", dbg_data);
    end
  endtask

  task automatic test_write_read();
    exp_t e;
    exp_t o;
    bit   st;
    drive('0, '0, 1'b0, 1'b1, 5'd3, 32'h1234_5678, 1'b0, 5'd0, 1'b0);
    #1 model_step(e, st);
    @(posedge clock); #1;
    drive(rtype(5'd3, 5'd0, 5'd4), 11'h010, 1'b1, 1'b0, 5'd0, '0,
          1'b0, 5'd0, 1'b0);
    #1 model_step(e, st);
    @(posedge clock); #1;
    o = observe();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL add_r4_r3: got %h want %h", o, e);
    end
    checks++;
    if ({data_a, RegDst_out, ALUOp_out, ex_valid}
        !== {32'h1234_5678, 1'b1, 2'b10, 1'b1}) begin
      errors++;
      $display("FAIL add_fields: got %h %b %b %b want 12345678 1 10 1",
               data_a, RegDst_out, ALUOp_out, ex_valid);
    end
    drive('0, '0, 1'b0, 1'b1, 5'd0, 32'h0000_FFFF, 1'b0, 5'd0, 1'b0);
    #1 model_step(e, st);
    @(posedge clock); #1;
    wb_reg_write = 1'b0;
    dbg_addr = 5'd0;
    #1;
    checks++;
    if (dbg_data !== '0) begin
      errors++;
      $display("FAIL r0_write: got %h want 0", dbg_data);
    end
    dbg_addr = 5'd3;
    #1;
    checks++;
    if (dbg_data !== 32'h1234_5678) begin
      errors++;
      $display("FAIL dbg_r3: got %h want 12345678", dbg_data);
    end
  endtask

  task automatic test_load_use();
    exp_t e;
    exp_t o;
    bit   st;
    drive(itype(6'h23, 5'd1, 5'd2, 16'd0), 11'h020, 1'b1, 1'b0,
          5'd0, '0, 1'b0, 5'd0, 1'b0);
    #1 model_step(e, st);
    @(posedge clock); #1;
    drive(rtype(5'd2, 5'd1, 5'd5), 11'h021, 1'b1, 1'b0, 5'd0, '0,
          1'b1, 5'd2, 1'b0);
    #1;
    model_step(e, st);
    checks++;
    if (stall !== 1'b1 || st !== 1'b1) begin
      errors++;
      $display("FAIL lu_stall: got %b want 1", stall);
    end
    @(posedge clock); #1;
    o = observe();
    checks++;
    if (o !== e || ex_valid !== 1'b0) begin
      errors++;
      $display("FAIL lu_bubble: got %h want %h", o, e);
    end
    ex_mem_read = 1'b0;
    #1;
    model_step(e, st);
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL lu_one_cycle: got %b want 0", stall);
    end
    @(posedge clock); #1;
    o = observe();
    checks++;
    if (o !== e || ex_valid !== 1'b1) begin
      errors++;
      $display("FAIL lu_reissue: got %h want %h", o, e);
    end
    drive(itype(6'h08, 5'd7, 5'd2, 16'd5), 11'h022, 1'b1, 1'b0,
          5'd0, '0, 1'b1, 5'd2, 1'b0);
    #1;
    model_step(e, st);
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL addi_rt_nostall: got %b want 0", stall);
    end
    @(posedge clock); #1;
    o = observe();
    checks++;
    if (o !== e || ex_valid !== 1'b1) begin
      errors++;
      $display("FAIL addi_load: got %h want %h", o, e);
    end
  endtask

  task automatic test_flush();
    exp_t e;
    exp_t o;
    bit   st;
    drive(rtype(5'd2, 5'd1, 5'd5), 11'h030, 1'b1, 1'b0, 5'd0, '0,
          1'b1, 5'd2, 1'b1);
    #1;
    model_step(e, st);
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall: got %b want 0", stall);
    end
    @(posedge clock); #1;
    o = observe();
    checks++;
    if (o !== '0 || e !== '0) begin
      errors++;
      $display("FAIL flush_bubble: got %h want 0", o);
    end
  endtask

  task automatic test_branch();
    exp_t e;
    exp_t o;
    bit   st;
    drive(itype(6'h04, 5'd1, 5'd2, 16'h0001), 11'h7FE, 1'b1, 1'b0,
          5'd0, '0, 1'b0, 5'd0, 1'b0);
    #1 model_step(e, st);
    @(posedge clock); #1;
    o = observe();
    checks++;
    if (branch_target !== 11'h002 || Branch_out !== 1'b1 || o !== e) begin
      errors++;
      $display("FAIL bt_wrap: got %h want 002 (%h vs %h)",
               branch_target, o, e);
    end
    drive(itype(6'h04, 5'd1, 5'd2, 16'hFFFF), 11'h7FE, 1'b1, 1'b0,
          5'd0, '0, 1'b0, 5'd0, 1'b0);
    #1 model_step(e, st);
    @(posedge clock); #1;
    o = observe();
    checks++;
    if (branch_target !== 11'h7FA || sign_extended !== 32'hFFFF_FFFF
        || o !== e) begin
      errors++;
      $display("FAIL bt_neg: got %h %h want 7fa ffffffff",
               branch_target, sign_extended);
    end
  endtask

  task automatic test_bypass();
    exp_t          e;
    exp_t          o;
    bit            st;
    logic [DW-1:0] want;
    drive('0, '0, 1'b0, 1'b1, 5'd9, 32'h0000_1111, 1'b0, 5'd0, 1'b0);
    #1 model_step(e, st);
    @(posedge clock); #1;
`ifdef ID_WB_BYPASS_EN
    want = 32'h0000_AAAA;
`else
    want = 32'h0000_1111;
`endif
    drive(rtype(5'd9, 5'd0, 5'd1), 11'h040, 1'b1, 1'b1, 5'd9,
          32'h0000_AAAA, 1'b0, 5'd0, 1'b0);
    dbg_addr = 5'd9;
    #1;
    checks++;
    if (dbg_data !== want) begin
      errors++;
      $display("FAIL bypass_dbg: got %h want %h", dbg_data, want);
    end
    model_step(e, st);
    @(posedge clock); #1;
    o = observe();
    checks++;
    if (data_a !== want || o !== e) begin
      errors++;
      $display("FAIL bypass_data_a: got %h want %h", data_a, want);
    end
    wb_reg_write = 1'b0;
    #1;
    checks++;
    if (dbg_data !== 32'h0000_AAAA) begin
      errors++;
      $display("FAIL bypass_after: got %h want 0000aaaa", dbg_data);
    end
  endtask

  task automatic test_illegal();
    exp_t e;
    exp_t o;
    bit   st;
    drive(itype(6'h3F, 5'd1, 5'd2, 16'h1234), 11'h050, 1'b1, 1'b0,
          5'd0, '0, 1'b0, 5'd0, 1'b0);
    #1 model_step(e, st);
    @(posedge clock); #1;
    o = observe();
    checks++;
    if (o.ctl !== 10'b0000000001 || ex_valid !== 1'b1 || o !== e) begin
      errors++;
      $display("FAIL illegal_3f: got %h want %h", o, e);
    end
  endtask

  task automatic test_random();
    exp_t          e;
    exp_t          o;
    bit            st;
    logic [5:0]    ops [6];
    logic [5:0]    op;
    logic [DW-1:0] dw;
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h3F};
    for (int n = 0; n < 400; n++) begin
      op = ops[$urandom_range(0, 5)];
      if (op == 6'h3F) op = 6'($urandom);
      drive({op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             16'($urandom)},
            PW'($urandom), ($urandom_range(0, 9) < 8),
            1'($urandom), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom), 5'($urandom_range(0, 7)),
            ($urandom_range(0, 9) == 0));
      dbg_addr = 5'($urandom_range(0, 7));
      #1;
      dw = mread(dbg_addr);
      checks++;
      if (dbg_data !== dw) begin
        errors++;
        $display("FAIL rnd_dbg[%0d]: got %h want %h", n, dbg_data, dw);
      end
      model_step(e, st);
      checks++;
      if (stall !== st) begin
        errors++;
        $display("FAIL rnd_stall[%0d]: got %b want %b", n, stall, st);
      end
      @(posedge clock); #1;
      o = observe();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL rnd_idex[%0d]: got %h want %h", n, o, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    exp_t o;
    bit   st;
    drive(rtype(5'd1, 5'd2, 5'd3), 11'h060, 1'b1, 1'b1, 5'd5,
          32'h0000_DEAD, 1'b0, 5'd0, 1'b0);
    #1 model_step(e, st);
    @(posedge clock); #1;
    wb_reg_write = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    model_clear();
    o = observe();
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL reset_mid: got %h want 0", o);
    end
    #2 reset_n = 1'b1;
    dbg_addr = 5'd5;
    #1;
    checks++;
    if (dbg_data !== '0) begin
      errors++;
      $display("FAIL reset_r5: got %h want 0", dbg_data);
    end
  endtask

  initial begin
    model_clear();
    #2;
    test_reset();
    #1 reset_n = 1'b1;
    @(posedge clock); #1;
    test_write_read();
    test_load_use();
    test_flush();
    test_branch();
    test_bypass();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
